// File: rtl/sincos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sincos_pkg
//  Purpose  : Shared constants, FSM state type and the pi/2 fixed-point helper
//             for the sincos argument range reducer.
//  Revision : 1.0 - initial release
// ============================================================================
package sincos_pkg;

    // pi/2 and the canonical quiet NaN as IEEE-754 single bit patterns
    localparam logic [31:0] PIO2_F32 = 32'h3FC90FDB;
    localparam logic [31:0] QNAN_F32 = 32'h7FC00000;

    // pi/2 scaled by 2^124, enough headroom for any practical FRAC_W
    localparam logic [127:0] PIO2_Q124 = 128'h1921FB54442D18469898CC51701B839A;

    // Reducer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_REDUCE = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // pi/2 rounded (half up) to frac_w fraction bits
    function automatic logic [127:0] pio2_fix(input int frac_w);
        logic [127:0] t;
        t = PIO2_Q124 >> (124 - frac_w - 1);
        return (t + 128'd1) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_fix_to_float.sv
`default_nettype none
// ============================================================================
//  Module   : fp_fix_to_float
//  Purpose  : Combinational unsigned fixed-point to IEEE-754 single converter.
//             Leading-one detect, truncate the 23 bits below it, pack.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_fix_to_float #(
    parameter int W      = 47,
    parameter int FRAC_W = 40
) (
    input  logic [W-1:0] i_fix,
    output logic [31:0]  o_f32
);

    localparam int            PW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0] c_TOP_POS = PW'(W - 1);
    localparam logic [7:0]    c_EXP_OFS = 8'(127 - FRAC_W);

    logic [PW-1:0] w_lead;
    logic          w_nz;
    logic [PW-1:0] w_shamt;
    logic [W+22:0] w_ext;
    logic [22:0]   w_mant;
    logic [7:0]    w_exp;

    // Leading-one detector: the highest set bit wins
    always_comb begin
        w_lead = '0;
        w_nz   = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_fix[i]) begin
                w_lead = PW'(i);
                w_nz   = 1'b1;
            end
        end
    end

    // Shift the leading one to the top of a zero-padded word; the next 23 bits
    // are the truncated mantissa (zero-filled when fewer bits exist)
    assign w_shamt = c_TOP_POS - w_lead;
    assign w_ext   = {i_fix, 23'b0} << w_shamt;
    assign w_mant  = 23'(w_ext >> (W - 1));
    assign w_exp   = c_EXP_OFS + 8'(w_lead);
    assign o_f32   = w_nz ? {1'b0, w_exp, w_mant} : 32'd0;

endmodule
`default_nettype wire

// File: rtl/fp_range_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : fp_range_reduce
//  Purpose  : Multi-cycle range reducer ahead of sincos. Reduces |x| modulo
//             pi/2 by restoring shift-subtract and returns the reduced angle,
//             the quadrant and the input sign, with valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_range_reduce #(
    parameter int INT_W  = 7,
    parameter int FRAC_W = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] red_x,
    output logic [1:0]  quadrant,
    output logic        neg,
    output logic        range_err
);
    import sincos_pkg::*;

    localparam int            W            = INT_W + FRAC_W;
    localparam int            KW           = (INT_W > 1) ? $clog2(INT_W) : 1;
    localparam logic [W-1:0]  PIO2_FIX     = W'(pio2_fix(FRAC_W));
    localparam logic [KW-1:0] c_K_LAST     = KW'(INT_W - 1);
    localparam logic [8:0]    c_EXP_LIMIT  = 9'(127 + INT_W);
    localparam logic [7:0]    c_ALIGN_BIAS = 8'(127 + 23 - FRAC_W);

    state_t        r_state;
    logic [31:0]   r_opx;
    logic [W-1:0]  r_rem;
    logic [KW-1:0] r_k;
    logic [1:0]    r_q2;
    logic [31:0]   r_red_x;
    logic [1:0]    r_quadrant;
    logic          r_neg;
    logic          r_range_err;
    logic          r_out_valid;

    logic          w_is_err;
    logic          w_is_byp;
    logic [7:0]    w_align_sh;
    logic [W-1:0]  w_fix;
    logic [W-1:0]  w_step;
    logic          w_take;
    logic [31:0]   w_norm_f32;

    // Classification of the captured operand (used in LOAD)
    assign w_is_err   = (r_opx[30:23] == 8'hFF) || ({1'b0, r_opx[30:23]} >= c_EXP_LIMIT);
    assign w_is_byp   = ({1'b0, r_opx[30:0]} < PIO2_F32);

    // Alignment of {1,mantissa} so that FRAC_W bits sit below the binary point
    assign w_align_sh = r_opx[30:23] - c_ALIGN_BIAS;
    assign w_fix      = W'({1'b1, r_opx[22:0]}) << w_align_sh;

    // One restoring step: compare against pi/2 scaled by 2^k
    assign w_step     = PIO2_FIX << r_k;
    assign w_take     = (r_rem >= w_step);

    fp_fix_to_float #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) u_norm (
        .i_fix (r_rem),
        .o_f32 (w_norm_f32)
    );

    // Reducer FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opx       <= '0;
            r_rem       <= '0;
            r_k         <= '0;
            r_q2        <= '0;
            r_red_x     <= '0;
            r_quadrant  <= '0;
            r_neg       <= 1'b0;
            r_range_err <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_opx   <= opx;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_neg      <= r_opx[31];
                    r_quadrant <= 2'd0;
                    if (w_is_err) begin
                        r_red_x     <= QNAN_F32;
                        r_range_err <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_is_byp) begin
                        r_red_x     <= {1'b0, r_opx[30:0]};
                        r_range_err <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_range_err <= 1'b0;
                        r_rem       <= w_fix;
                        r_k         <= c_K_LAST;
                        r_q2        <= 2'd0;
                        r_state     <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    // Quotient bits arrive MSB first; only the low two matter
                    if (w_take) begin
                        r_rem <= r_rem - w_step;
                    end
                    r_q2 <= {r_q2[0], w_take};
                    if (r_k == '0) begin
                        r_state <= ST_NORM;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                ST_NORM: begin
                    r_red_x     <= w_norm_f32;
                    r_quadrant  <= r_q2;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign red_x     = r_red_x;
    assign quadrant  = r_quadrant;
    assign neg       = r_neg;
    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_range_reduce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fp_range_reduce
//  Purpose  : Randomised and directed self-checking bench for fp_range_reduce.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_range_reduce;

    localparam int INT_W  = 7;
    localparam int FRAC_W = 40;
    // round(pi/2 * 2^40)
    localparam longint unsigned PIO2_FIX_TB = 64'h1921FB54443;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] opx = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] red_x;
    logic [1:0]  quadrant;
    logic        neg;
    logic        range_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] red;
        logic [1:0]  quad;
        logic        neg;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    fp_range_reduce #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opx       (opx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .red_x     (red_x),
        .quadrant  (quadrant),
        .neg       (neg),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: |x| = q*P + rem with P = pi/2 in 2^-40 units, rem packed as float
    function automatic exp_t model(input logic [31:0] x);
        exp_t             r;
        int               e;
        int               p;
        longint unsigned  xf;
        longint unsigned  q;
        longint unsigned  rem;
        logic [22:0]      m;
        e     = int'(x[30:23]);
        r.neg = x[31];
        r.quad = 2'd0;
        r.err  = 1'b0;
        r.lat  = 8'd2;
        if (e == 255 || e >= 127 + INT_W) begin
            r.red = 32'h7FC00000;
            r.err = 1'b1;
        end else if (x[30:0] < 31'h3FC90FDB) begin
            r.red = {1'b0, x[30:0]};
        end else begin
            xf    = {40'b0, 1'b1, x[22:0]} << (e - 127 + FRAC_W - 23);
            q     = xf / PIO2_FIX_TB;
            rem   = xf % PIO2_FIX_TB;
            r.quad = q[1:0];
            r.lat  = 8'(INT_W + 3);
            if (rem == 0) begin
                r.red = 32'd0;
            end else begin
                p = 0;
                for (int i = 0; i < 64; i++) if (rem[i]) p = i;
                if (p >= 23) m = 23'(rem >> (p - 23));
                else         m = 23'(rem << (23 - p));
                r.red = {1'b0, 8'(127 + p - FRAC_W), m};
            end
        end
        return r;
    endfunction

    function automatic logic ulp_close(input logic [31:0] a, input logic [31:0] b);
        int d;
        d = int'(a) - int'(b);
        return (d <= 2) && (d >= -2);
    endfunction

    // Compare process: tracks acceptances and checks every result it sees
    int          ncyc = 0;
    logic        seen = 1'b0;
    logic [35:0] held = '0;
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            seen = 1'b0;
        end else begin
            check("ready_valid_exclusive", {63'b0, in_ready & out_valid}, 64'd0);
            if (out_valid) begin
                if (!seen) begin
                    check("pending_results", 64'(exp_q.size()), 64'd1);
                    if (exp_q.size() > 0) begin
                        check("latency",   64'(ncyc - acc_q[0]), 64'(exp_q[0].lat));
                        check("red_x",     64'(red_x),     64'(exp_q[0].red));
                        check("quadrant",  64'(quadrant),  64'(exp_q[0].quad));
                        check("neg",       64'(neg),       64'(exp_q[0].neg));
                        check("range_err", 64'(range_err), 64'(exp_q[0].err));
                    end
                    seen = 1'b1;
                    held = {red_x, quadrant, neg, range_err};
                end else begin
                    check("hold_stable", 64'({red_x, quadrant, neg, range_err}), 64'(held));
                end
                if (out_ready) begin
                    if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                    seen = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(opx));
                acc_q.push_back(ncyc);
            end
        end
    end

    task automatic send(input logic [31:0] x, input int hold);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #2; t++; end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        opx      = x;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        opx      = $urandom;
        t = 0;
        while (!out_valid && t < 30) begin @(posedge clk); #2; t++; end
        check("out_valid_wait", 64'(out_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            check("in_ready_backpressure", 64'(in_ready), 64'd0);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        int         sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(134, 140));
            default: e = 8'($urandom_range(110, 133));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    exp_t pm;

    initial begin
        // Model pins (hand-derived values)
        pm = model(32'h3F490FDB);
        check("pin_pio4_red", 64'(pm.red), 64'h3F490FDB);
        pm = model(32'h40490FDB);
        check("pin_pi_quad", 64'(pm.quad), 64'd2);
        check("pin_pi_exp", 64'(pm.red[30:23]), 64'd103);
        pm = model(32'hC0A00000);   // 5 - 3*pi/2 = 0.2876110196
        check("pin_m5_quad", 64'(pm.quad), 64'd3);
        check("pin_m5_red", 64'(ulp_close(pm.red, 32'h3E9341C0)), 64'd1);
        pm = model(32'h43480000);
        check("pin_200_err", 64'({pm.err, pm.red}), 64'h1_7FC00000);
        pm = model(32'h4016CBE4);
        check("pin_3pio4_quad", 64'(pm.quad), 64'd1);
        check("pin_3pio4_red", 64'(ulp_close(pm.red, 32'h3F490FDB)), 64'd1);

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_in_ready",  64'(in_ready), 64'd1);
        check("reset_outputs", 64'({out_valid, red_x, quadrant, neg, range_err}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Directed cases incl. boundaries
        send(32'h3F490FDB, 0);   // pi/4 bypass
        send(32'h40490FDB, 0);   // pi
        send(32'hC0A00000, 0);   // -5.0
        send(32'h43480000, 0);   // 200 -> error
        send(32'h7F800000, 0);   // +Inf
        send(32'hFFC12345, 0);   // NaN
        send(32'h00000000, 0);
        send(32'h80000000, 0);
        send(32'h00400001, 0);   // denormal
        send(32'h3FC90FDA, 0);   // just below pi/2 pattern
        send(32'h3FC90FDB, 0);   // pi/2 pattern itself
        send(32'h42FFFFFF, 0);   // largest in range
        send(32'h43000000, 0);   // 128.0 -> error

        // Backpressure then back-to-back
        send(32'h40490FDB, 5);
        send(32'hC0A00000, 0);

        // Reset during the 4th REDUCE iteration
        out_ready = 1'b1;
        opx = 32'h40A00000;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_outputs", 64'({out_valid, red_x, quadrant, neg, range_err}), 64'd0);
        repeat (15) begin @(posedge clk); #2; end
        check("midreset_no_stale", 64'(out_valid), 64'd0);
        send(32'h4016CBE4, 0);   // 3*pi/4

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            send(rand_fp(), $urandom_range(0, 3));
        end

        repeat (5) begin @(posedge clk); #2; end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
